// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared opcode encodings, sequencer state encoding and widths
//               for the single-bus execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int OP_W    = 5;
    localparam int STATE_W = 3;

    // Opcode encodings; everything above OP_MUL is illegal.
    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR  = 5'd3;
    localparam logic [OP_W-1:0] OP_SHL = 5'd4;
    localparam logic [OP_W-1:0] OP_SHR = 5'd5;
    localparam logic [OP_W-1:0] OP_NOT = 5'd6;
    localparam logic [OP_W-1:0] OP_NEG = 5'd7;
    localparam logic [OP_W-1:0] OP_MUL = 5'd8;

    // Sequencer T-states.
    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_TY   = 3'd1;
    localparam logic [STATE_W-1:0] S_TZ   = 3'd2;
    localparam logic [STATE_W-1:0] S_TWB  = 3'd3;
    localparam logic [STATE_W-1:0] S_THI  = 3'd4;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/bus_alu.sv
`default_nettype none
// ============================================================================
// Module      : bus_alu
// Description : Combinational ALU for the single-bus datapath. Produces a
//               double-width result (full signed product for MUL, upper half
//               zero otherwise) and flags opcodes outside the legal set.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [OP_W-1:0]     op_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                illegal_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     w_shamt;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_lo;
    logic                w_is_mul;

    // Shift distance uses only the low bits of B, so large B values wrap.
    assign w_shamt = b_i[SH_W-1:0];

    // Sign-extend both operands to full width so the low 2*DATA_W bits of the
    // unsigned product equal the signed product.
    assign w_prod = {{DATA_W{a_i[DATA_W-1]}}, a_i} * {{DATA_W{b_i[DATA_W-1]}}, b_i};

    // Opcode decode and single-width result selection.
    always_comb begin
        w_lo      = '0;
        w_is_mul  = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  w_lo = a_i + b_i;
            OP_SUB:  w_lo = a_i - b_i;
            OP_AND:  w_lo = a_i & b_i;
            OP_OR:   w_lo = a_i | b_i;
            OP_SHL:  w_lo = a_i << w_shamt;
            OP_SHR:  w_lo = a_i >> w_shamt;
            OP_NOT:  w_lo = ~b_i;
            OP_NEG:  w_lo = '0 - b_i;
            OP_MUL:  w_is_mul = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    assign result_o = w_is_mul ? w_prod : {{DATA_W{1'b0}}, w_lo};

endmodule : bus_alu
`default_nettype wire

// File: rtl/bus_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_exec_unit
// Description : Self-timed single-bus execution unit. Register file, Y/Z
//               operand latches, HI/LO and the ALU share one internal bus; a
//               T-state sequencer executes ra <- rb op rc per accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_exec_unit
    import datapath_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter bit ZERO_R0  = 1'b0,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              ready,
    input  logic [OP_W-1:0]   op,
    input  logic [IDX_W-1:0]  ra,
    input  logic [IDX_W-1:0]  rb,
    input  logic [IDX_W-1:0]  rc,
    output logic              done,
    output logic              err,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] hi_data,
    output logic [DATA_W-1:0] lo_data
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [IDX_W-1:0]    ra_q, rb_q, rc_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   y_q, hi_q, lo_q;
    logic [2*DATA_W-1:0] z_q;
    logic                done_q, err_q;

    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_rb_val, w_rc_val;
    logic [OP_W-1:0]     w_alu_op;
    logic [2*DATA_W-1:0] w_alu_res;
    logic                w_alu_illegal;
    logic                w_idle, w_accept, w_is_mul;
    logic                w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    assign w_idle   = (state_q == S_IDLE);
    assign w_accept = w_idle && start;
    assign w_is_mul = (op_q == OP_MUL);

    // R0 reads as zero when hardwired; otherwise a plain array read.
    assign w_rb_val = (ZERO_R0 && rb_q == '0)    ? '0 : regs_q[rb_q];
    assign w_rc_val = (ZERO_R0 && rc_q == '0)    ? '0 : regs_q[rc_q];
    assign rd_data  = (ZERO_R0 && rd_addr == '0) ? '0 : regs_q[rd_addr];

    // In IDLE the ALU decodes the incoming opcode so legality is known at
    // acceptance; afterwards it works on the latched opcode.
    assign w_alu_op = w_idle ? op : op_q;

    bus_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i       (y_q),
        .b_i       (w_bus),
        .op_i      (w_alu_op),
        .result_o  (w_alu_res),
        .illegal_o (w_alu_illegal)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Sequencer next-state logic; illegal opcodes never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !w_alu_illegal) state_d = S_TY;
            S_TY:    state_d = S_TZ;
            S_TZ:    state_d = S_TWB;
            S_TWB:   state_d = w_is_mul ? S_THI : S_IDLE;
            S_THI:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer outputs: handshake and bus source selection.
    always_comb begin
        ready = 1'b0;
        w_bus = '0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_TY:    w_bus = w_rb_val;
            S_TZ:    w_bus = w_rc_val;
            S_TWB:   w_bus = z_q[DATA_W-1:0];
            S_THI:   w_bus = z_q[2*DATA_W-1:DATA_W];
            default: w_bus = '0;
        endcase
    end

    // Single register-file write port shared by direct load and writeback.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_idle && ld_en) begin
            w_we    = 1'b1;
            w_waddr = ld_addr;
            w_wdata = ld_data;
        end else if (state_q == S_TWB && !w_is_mul) begin
            w_we    = 1'b1;
            w_waddr = ra_q;
            w_wdata = w_bus;
        end
        if (ZERO_R0 && w_waddr == '0) w_we = 1'b0;
    end

    // Register file storage.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (w_we) begin
            regs_q[w_waddr] <= w_wdata;
        end
    end

    // Instruction fields are captured only at acceptance.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (w_accept) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
        end
    end

    // Operand and result latches loaded from the bus in their T-states.
    always_ff @(posedge clk) begin
        if (clr) begin
            y_q  <= '0;
            z_q  <= '0;
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            if (state_q == S_TY)               y_q  <= w_bus;
            if (state_q == S_TZ)               z_q  <= w_alu_res;
            if (state_q == S_TWB && w_is_mul)  lo_q <= w_bus;
            if (state_q == S_THI)              hi_q <= w_bus;
        end
    end

    // Completion flags, registered so they pulse in the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (w_accept && w_alu_illegal)
                    || (state_q == S_TWB && !w_is_mul)
                    || (state_q == S_THI);
            err_q  <= w_accept && w_alu_illegal;
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign bus_data = w_bus;
    assign hi_data  = hi_q;
    assign lo_data  = lo_q;

endmodule : bus_exec_unit
`default_nettype wire

// File: tb/tb_bus_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_exec_unit
// Description : Directed self-checking bench for bus_exec_unit (ZERO_R0=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_exec_unit;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;

    logic              clk = 1'b0;
    logic              clr, start, ld_en;
    logic [4:0]        op;
    logic [IDX_W-1:0]  ra, rb, rc, ld_addr, rd_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ready, done, err;
    logic [DATA_W-1:0] rd_data, bus_data, hi_data, lo_data;

    int n_checks = 0;
    int n_errors = 0;

    bus_exec_unit #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (1'b1)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .ready    (ready),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .done     (done),
        .err      (err),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .bus_data (bus_data),
        .hi_data  (hi_data),
        .lo_data  (lo_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] val);
        ld_en = 1'b1; ld_addr = idx; ld_data = val;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] exp);
        rd_addr = idx;
        #1;
        chk(tag, rd_data, exp);
    endtask

    // Returns one cycle after the accepting edge (the TY cycle for legal ops).
    task automatic issue(input logic [4:0] o, input logic [IDX_W-1:0] d,
                         input logic [IDX_W-1:0] s1, input logic [IDX_W-1:0] s2);
        start = 1'b1; op = o; ra = d; rb = s1; rc = s2;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after acceptance until done is seen; bounded.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; ld_en = 1'b0; op = '0;
        ra = '0; rb = '0; rc = '0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        tick(); tick();
        clr = 1'b0;

        // Reset state
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bus", bus_data, 0);
        chk("rst_hilo", {hi_data, lo_data}, 0);
        chk_reg("rst_r3", 3, 0);

        // ADD R1 = R2 + R3 with bus observation per T-state
        load(2, 32'd7);
        load(3, 32'd5);
        issue(5'd0, 1, 2, 3);
        chk("add_ty_bus", bus_data, 7);
        chk("add_ty_ready", ready, 0);
        tick();
        chk("add_tz_bus", bus_data, 5);
        tick();
        chk("add_twb_bus", bus_data, 12);
        tick();
        chk("add_done", done, 1);
        chk("add_err", err, 0);
        chk_reg("add_r1", 1, 12);
        tick();
        chk("add_done_pulse", done, 0);

        // MUL of large positives; destination untouched
        load(4, 32'h0001_0000);
        load(5, 32'h0003_0000);
        load(9, 32'h0000_DEAD);
        issue(5'd8, 9, 4, 5);
        wait_done("mul1_lat", 4);
        chk("mul1_hi", hi_data, 32'h0000_0003);
        chk("mul1_lo", lo_data, 32'h0000_0000);
        chk_reg("mul1_r9", 9, 32'h0000_DEAD);
        tick();

        // Signed MUL -2 * 3
        load(6, 32'hFFFF_FFFE);
        load(7, 32'd3);
        issue(5'd8, 10, 6, 7);
        wait_done("mul2_lat", 4);
        chk("mul2_hi", hi_data, 32'hFFFF_FFFF);
        chk("mul2_lo", lo_data, 32'hFFFF_FFFA);
        tick();

        // SHR with shift amount 33 wrapping to 1
        load(7, 32'd33);
        issue(5'd5, 8, 6, 7);
        wait_done("shr_lat", 3);
        chk_reg("shr_r8", 8, 32'h7FFF_FFFF);
        tick();

        // Busy start ignored, busy load ignored, back-to-back issue in done cycle
        issue(5'd0, 11, 2, 3);
        tick();
        start = 1'b1; op = 5'd1; ra = 12; rb = 3; rc = 2;
        ld_en = 1'b1; ld_addr = 2; ld_data = 32'd100;
        tick();
        start = 1'b0; ld_en = 1'b0;
        chk("busy_ready", ready, 0);
        tick();
        chk("b2b_done1", done, 1);
        chk_reg("b2b_r11", 11, 12);
        issue(5'd1, 13, 2, 3);
        chk("b2b_accepted", ready, 0);
        wait_done("b2b_lat", 3);
        chk_reg("b2b_r13", 13, 2);
        chk_reg("busy_start_r12", 12, 0);
        chk_reg("busy_ld_r2", 2, 7);
        tick();

        // clr during TZ aborts with no done and clears everything
        load(1, 32'd9);
        issue(5'd0, 1, 2, 3);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ready", ready, 1);
        chk("clr_done", done, 0);
        chk_reg("clr_r1", 1, 0);
        chk_reg("clr_r2", 2, 0);
        chk("clr_hilo", {hi_data, lo_data}, 0);
        tick();
        chk("clr_done_after", done, 0);

        // Hardwired R0
        load(0, 32'd5);
        chk_reg("r0_read", 0, 0);
        load(2, 32'd1);
        issue(5'd1, 1, 0, 2);
        wait_done("sub_r0_lat", 3);
        chk_reg("sub_r0_r1", 1, 32'hFFFF_FFFF);
        tick();
        issue(5'd0, 0, 2, 2);
        wait_done("wb_r0_lat", 3);
        chk_reg("wb_r0_read", 0, 0);
        tick();

        // Illegal opcode: immediate done+err, no state change
        issue(5'h1F, 1, 2, 2);
        chk("ill_ready", ready, 1);
        wait_done("ill_lat", 0);
        chk("ill_err", err, 1);
        chk_reg("ill_r1", 1, 32'hFFFF_FFFF);
        tick();
        chk("ill_pulse", {done, err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bus_exec_unit
`default_nettype wire
